// File: rtl/io_bridge_if.sv
// Signal bundle between io_bridge and its system-side partners
// (word producer, word consumer, processor In/Out/Int pins).
interface io_bridge_if #(
  parameter int unsigned DW       = 16,
  parameter int unsigned IN_DEPTH = 4
);
  localparam int unsigned ICW = $clog2(IN_DEPTH + 1);

  logic [DW-1:0]  dev_in_data;
  logic           dev_in_valid;
  logic           dev_in_ready;
  logic [DW-1:0]  cpu_In;
  logic           cpu_Int;
  logic [DW-1:0]  cpu_Out;
  logic [DW-1:0]  dev_out_data;
  logic           dev_out_valid;
  logic           dev_out_ready;
  logic           clr_ovf;
  logic           out_overflow;
  logic [ICW-1:0] in_count;

  // System side: producer, consumer and processor pins
  modport master (
    output dev_in_data, dev_in_valid,
    input  dev_in_ready,
    input  cpu_In, cpu_Int,
    output cpu_Out,
    input  dev_out_data, dev_out_valid,
    output dev_out_ready, clr_ovf,
    input  out_overflow, in_count
  );

  // Bridge side
  modport slave (
    input  dev_in_data, dev_in_valid,
    output dev_in_ready,
    output cpu_In, cpu_Int,
    input  cpu_Out,
    output dev_out_data, dev_out_valid,
    input  dev_out_ready, clr_ovf,
    output out_overflow, in_count
  );
endinterface

// File: rtl/io_bridge.sv
// io_bridge: feeds buffered producer words to the processor In bus with an
// Int pulse per word, and captures every change of the processor Out bus
// into a FIFO for an external consumer.
module io_bridge #(
  parameter int unsigned DW        = 16,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned INT_LEN   = 2,
  parameter int unsigned INT_HOLD  = 8
) (
  input logic       Clk,
  input logic       Rst,
  io_bridge_if.slave bus
);
  localparam int unsigned IAW  = $clog2(IN_DEPTH);
  localparam int unsigned ICW  = $clog2(IN_DEPTH + 1);
  localparam int unsigned OAW  = $clog2(OUT_DEPTH);
  localparam int unsigned OCW  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned TMAX = (INT_LEN > INT_HOLD) ? INT_LEN : INT_HOLD;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  // Input side
  logic [DW-1:0]  in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr, in_rd;
  logic [ICW-1:0] in_cnt;
  logic           in_push, in_pop;
  logic [DW-1:0]  in_word;
  logic           int_q, int_n;
  state_t         state, state_n;
  logic [TW-1:0]  tmr, tmr_n;

  // Output side
  logic [DW-1:0]  out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr, out_rd;
  logic [OCW-1:0] out_cnt;
  logic [DW-1:0]  out_prev;
  logic           out_change, out_push, out_pop, out_drop, ovf_q;

  assign bus.dev_in_ready  = (in_cnt != ICW'(IN_DEPTH));
  assign bus.in_count      = in_cnt;
  assign bus.cpu_In        = in_word;
  assign bus.cpu_Int       = int_q;
  assign bus.dev_out_valid = (out_cnt != '0);
  assign bus.dev_out_data  = out_mem[out_rd];
  assign bus.out_overflow  = ovf_q;

  assign in_push    = bus.dev_in_valid & bus.dev_in_ready;
  assign out_pop    = (out_cnt != '0) & bus.dev_out_ready;
  assign out_change = (bus.cpu_Out != out_prev);
  // A full FIFO still accepts the new word when its head leaves on the same edge
  assign out_push   = out_change & ((out_cnt != OCW'(OUT_DEPTH)) | out_pop);
  assign out_drop   = out_change & ~out_push;

  // Input FIFO storage write
  always_ff @(posedge Clk) begin
    if (in_push) in_mem[in_wr] <= bus.dev_in_data;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + IAW'(1);
      if (in_pop)  in_rd <= in_rd + IAW'(1);
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + ICW'(1);
        2'b01:   in_cnt <= in_cnt - ICW'(1);
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  // Delivery FSM state, timer and registered In/Int outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      tmr     <= '0;
      int_q   <= 1'b0;
      in_word <= '0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      int_q <= int_n;
      if (in_pop) in_word <= in_mem[in_rd];
    end
  end

  // Delivery FSM next state: load, pulse Int for INT_LEN, then hold for INT_HOLD
  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    int_n   = int_q;
    in_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (in_cnt != '0) begin
          in_pop  = 1'b1;
          int_n   = 1'b1;
          tmr_n   = '0;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (tmr == TW'(INT_LEN - 1)) begin
          int_n   = 1'b0;
          tmr_n   = '0;
          state_n = HOLD;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      HOLD: begin
        if (tmr == TW'(INT_HOLD - 1)) begin
          tmr_n   = '0;
          state_n = IDLE;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      default: begin
        int_n   = 1'b0;
        tmr_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Output FIFO storage write
  always_ff @(posedge Clk) begin
    if (out_push) out_mem[out_wr] <= bus.cpu_Out;
  end

  // Output capture: change detect, FIFO pointers, sticky overflow
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_wr   <= '0;
      out_rd   <= '0;
      out_cnt  <= '0;
      out_prev <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (out_change) out_prev <= bus.cpu_Out;
      if (out_push)   out_wr   <= out_wr + OAW'(1);
      if (out_pop)    out_rd   <= out_rd + OAW'(1);
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + OCW'(1);
        2'b01:   out_cnt <= out_cnt - OCW'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (out_drop)         ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end
endmodule
